// File: rtl/instr_memory.sv
// rtl/instr_memory.sv - byte-loadable instruction memory with a one-word fetch buffer
module instr_memory #(
    parameter int ADDR_W     = 10,
    parameter int WORD_BYTES = 4,
    parameter int READ_LAT   = 2
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [31:0]             PC,
    input  logic                    READ,
    output logic [8*WORD_BYTES-1:0] INSTRUCTION,
    output logic                    VALID,
    output logic                    BUSYWAIT,
    output logic                    MISALIGN,
    input  logic                    LOAD_EN,
    input  logic [ADDR_W-1:0]       LOAD_ADDR,
    input  logic [7:0]              LOAD_DATA
);

    localparam int WORD_W = 8 * WORD_BYTES;
    localparam int CNT_W  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(WORD_BYTES - 1);

    typedef enum logic {
        S_IDLE,
        S_FETCH
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   instr_q, instr_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                misalign_q, misalign_d;
    logic [ADDR_W-1:0]   buf_tag_q, buf_tag_d;
    logic [WORD_W-1:0]   buf_data_q, buf_data_d;
    logic                buf_valid_q, buf_valid_d;

    logic [7:0]          mem [0:(1 << ADDR_W) - 1];
    logic                mem_we;
    logic [ADDR_W-1:0]   pc_addr;
    logic                pc_misaligned;
    logic                buf_hit;
    logic [WORD_W-1:0]   fetch_word;
    logic                unused_pc_hi;

    // Only the low ADDR_W bits address the array; higher PC bits wrap away.
    assign pc_addr       = PC[ADDR_W-1:0];
    assign unused_pc_hi  = ^PC[31:ADDR_W];
    assign pc_misaligned = |(pc_addr & OFF_MASK);
    assign buf_hit       = buf_valid_q && (buf_tag_q == pc_addr);

    always_comb begin
        fetch_word = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            fetch_word[8*i +: 8] = mem[addr_q + ADDR_W'(i)];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        instr_d     = instr_q;
        valid_d     = 1'b0;
        busy_d      = busy_q;
        misalign_d  = 1'b0;
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;
        buf_valid_d = buf_valid_q;
        mem_we      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (LOAD_EN) begin
                    mem_we      = 1'b1;
                    buf_valid_d = 1'b0;
                end else if (READ) begin
                    if (pc_misaligned) begin
                        misalign_d = 1'b1;
                    end else if (buf_hit) begin
                        instr_d = buf_data_q;
                        valid_d = 1'b1;
                    end else begin
                        addr_d  = pc_addr;
                        cnt_d   = CNT_W'(READ_LAT - 1);
                        busy_d  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                // Inputs are deliberately ignored until the word is delivered.
                if (cnt_q == '0) begin
                    instr_d     = fetch_word;
                    valid_d     = 1'b1;
                    busy_d      = 1'b0;
                    buf_tag_d   = addr_q;
                    buf_data_d  = fetch_word;
                    buf_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            instr_q     <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            misalign_q  <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
            buf_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            misalign_q  <= misalign_d;
            buf_tag_q   <= buf_tag_d;
            buf_data_q  <= buf_data_d;
            buf_valid_q <= buf_valid_d;
        end
    end

    // Program contents survive reset.
    always_ff @(posedge CLK) begin
        if (!RESET && mem_we) begin
            mem[LOAD_ADDR] <= LOAD_DATA;
        end
    end

    assign INSTRUCTION = instr_q;
    assign VALID       = valid_q;
    assign BUSYWAIT    = busy_q;
    assign MISALIGN    = misalign_q;

endmodule

// File: tb/tb_instr_memory.sv
// tb/tb_instr_memory.sv - directed bench for instr_memory with a transaction-level reference model
module tb_instr_memory;

    localparam int ADDR_W = 10;
    localparam int LAT    = 2;

    logic        clk;
    logic        RESET;
    logic [31:0] PC;
    logic        READ;
    logic [31:0] INSTRUCTION;
    logic        VALID;
    logic        BUSYWAIT;
    logic        MISALIGN;
    logic        LOAD_EN;
    logic [9:0]  LOAD_ADDR;
    logic [7:0]  LOAD_DATA;

    int checks   = 0;
    int failures = 0;

    instr_memory #(.ADDR_W(ADDR_W), .WORD_BYTES(4), .READ_LAT(LAT)) dut (
        .CLK(clk),
        .RESET(RESET),
        .PC(PC),
        .READ(READ),
        .INSTRUCTION(INSTRUCTION),
        .VALID(VALID),
        .BUSYWAIT(BUSYWAIT),
        .MISALIGN(MISALIGN),
        .LOAD_EN(LOAD_EN),
        .LOAD_ADDR(LOAD_ADDR),
        .LOAD_DATA(LOAD_DATA)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: memory as a byte array, fetch buffer as (tag, data, valid),
    // and an outstanding miss described only by the edge number on which it completes.
    logic [7:0]  m_mem [0:1023];
    logic [31:0] m_buf_data;
    int          m_buf_tag;
    bit          m_buf_valid;
    bit          m_fetching;
    int          m_fetch_addr;
    int          m_done_edge;
    int          edge_n;
    logic [31:0] exp_instr;
    logic        exp_valid, exp_busy, exp_mis;

    function automatic logic [31:0] m_word(input int a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = m_mem[(a + i) % 1024];
        return w;
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) m_mem[i] = 8'h00;
        edge_n = 0; m_fetching = 0; m_buf_valid = 0; m_buf_tag = 0; m_buf_data = '0;
        exp_instr = '0; exp_valid = 0; exp_busy = 0; exp_mis = 0;
        forever begin
            int a;
            @(posedge clk);
            edge_n++;
            exp_valid = 0;
            exp_mis   = 0;
            if (RESET) begin
                m_fetching  = 0;
                m_buf_valid = 0;
                exp_instr   = '0;
                exp_busy    = 0;
            end else if (m_fetching) begin
                if (edge_n == m_done_edge) begin
                    exp_instr   = m_word(m_fetch_addr);
                    exp_valid   = 1;
                    exp_busy    = 0;
                    m_fetching  = 0;
                    m_buf_valid = 1;
                    m_buf_tag   = m_fetch_addr;
                    m_buf_data  = exp_instr;
                end
            end else if (LOAD_EN) begin
                m_mem[LOAD_ADDR] = LOAD_DATA;
                m_buf_valid = 0;
            end else if (READ) begin
                a = int'(PC % 1024);
                if (a % 4 != 0) begin
                    exp_mis = 1;
                end else if (m_buf_valid && m_buf_tag == a) begin
                    exp_instr = m_buf_data;
                    exp_valid = 1;
                end else begin
                    m_fetching   = 1;
                    m_fetch_addr = a;
                    m_done_edge  = edge_n + LAT;
                    exp_busy     = 1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("cyc_instr", INSTRUCTION, exp_instr);
            chk("cyc_valid", {31'd0, VALID}, {31'd0, exp_valid});
            chk("cyc_busy", {31'd0, BUSYWAIT}, {31'd0, exp_busy});
            chk("cyc_misalign", {31'd0, MISALIGN}, {31'd0, exp_mis});
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic load_byte(input int a, input logic [7:0] d);
        LOAD_EN = 1'b1; LOAD_ADDR = 10'(a); LOAD_DATA = d;
        step();
        LOAD_EN = 1'b0;
    endtask

    // Issues a one-cycle READ and counts BUSYWAIT cycles until it drops.
    task automatic miss_read(input logic [31:0] pc, output int bcnt);
        PC = pc; READ = 1'b1;
        step();
        READ = 1'b0;
        bcnt = 0;
        while (BUSYWAIT && bcnt < 20) begin
            bcnt++;
            step();
        end
    endtask

    initial begin
        int b;
        RESET = 1'b1; PC = '0; READ = 1'b0; LOAD_EN = 1'b0; LOAD_ADDR = '0; LOAD_DATA = '0;
        step(); step();
        RESET = 1'b0;
        chk("reset_instr", INSTRUCTION, 32'h0);
        chk("reset_valid", {31'd0, VALID}, 32'd0);
        chk("reset_busy", {31'd0, BUSYWAIT}, 32'd0);

        load_byte(0, 8'h05); load_byte(1, 8'h00); load_byte(2, 8'h04); load_byte(3, 8'h00);
        miss_read(32'h0, b);
        chk("miss0_busy_cycles", b, 32'd2);
        chk("miss0_valid", {31'd0, VALID}, 32'd1);
        chk("miss0_instr", INSTRUCTION, 32'h00040005);
        chk("model_miss0_instr", exp_instr, 32'h00040005);

        PC = 32'h0; READ = 1'b1;
        step();
        chk("hit_valid", {31'd0, VALID}, 32'd1);
        chk("hit_busy", {31'd0, BUSYWAIT}, 32'd0);
        chk("hit_instr", INSTRUCTION, 32'h00040005);
        step();
        chk("hit_b2b_valid", {31'd0, VALID}, 32'd1);
        READ = 1'b0;
        step();
        chk("idle_valid", {31'd0, VALID}, 32'd0);

        PC = 32'd6; READ = 1'b1;
        step();
        READ = 1'b0;
        chk("mis_pulse", {31'd0, MISALIGN}, 32'd1);
        chk("mis_valid", {31'd0, VALID}, 32'd0);
        chk("mis_instr", INSTRUCTION, 32'h00040005);
        step();
        chk("mis_clear", {31'd0, MISALIGN}, 32'd0);
        chk("mis_no_fetch", {31'd0, BUSYWAIT}, 32'd0);

        load_byte(4, 8'h13); load_byte(5, 8'h01); load_byte(6, 8'h10); load_byte(7, 8'h00);
        miss_read(32'h4, b);
        chk("miss4_busy_cycles", b, 32'd2);
        chk("miss4_instr", INSTRUCTION, 32'h00100113);
        miss_read(32'h400, b);
        chk("wrap_busy_cycles", b, 32'd2);
        chk("wrap_valid", {31'd0, VALID}, 32'd1);
        chk("wrap_instr", INSTRUCTION, 32'h00040005);

        LOAD_EN = 1'b1; LOAD_ADDR = 10'd0; LOAD_DATA = 8'hFF; PC = 32'h0; READ = 1'b1;
        step();
        LOAD_EN = 1'b0;
        chk("load_prio_valid", {31'd0, VALID}, 32'd0);
        chk("load_prio_busy", {31'd0, BUSYWAIT}, 32'd0);
        miss_read(32'h0, b);
        chk("reload_busy_cycles", b, 32'd2);
        chk("reload_instr", INSTRUCTION, 32'h000400FF);

        PC = 32'h4; READ = 1'b1;
        step();
        READ = 1'b0;
        chk("rst_fetch_started", {31'd0, BUSYWAIT}, 32'd1);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        chk("rst_busy", {31'd0, BUSYWAIT}, 32'd0);
        chk("rst_instr", INSTRUCTION, 32'h0);
        chk("rst_valid", {31'd0, VALID}, 32'd0);
        step();
        chk("rst_no_late_valid", {31'd0, VALID}, 32'd0);

        PC = 32'h4; READ = 1'b1;
        step();
        READ = 1'b1; PC = 32'h0; LOAD_EN = 1'b1; LOAD_ADDR = 10'd4; LOAD_DATA = 8'hAA;
        step();
        READ = 1'b0; LOAD_EN = 1'b0;
        b = 0;
        while (BUSYWAIT && b < 20) begin
            b++;
            step();
        end
        chk("post_rst_valid", {31'd0, VALID}, 32'd1);
        chk("post_rst_instr", INSTRUCTION, 32'h00100113);
        miss_read(32'h0, b);
        chk("fetch_ignores_load", INSTRUCTION, 32'h000400FF);
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_memory.md
INSTR_MEMORY -- requirements
Module: instr_memory

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning the byte-address width (memory depth 2^ADDR_W bytes).
REQ-002 The block SHALL have parameter WORD_BYTES, default 4, meaning bytes per instruction word (power of two, >=1).
REQ-003 The block SHALL have parameter READ_LAT, default 2, meaning the miss fetch latency in cycles (>=1).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, named as the codebase does: CLK and RESET.
REQ-005 The block SHALL have port CLK, input, 1 bit: the clock; all state changes on its rising edge.
REQ-006 The block SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port PC, input, 32 bits: the fetch byte address.
REQ-008 The block SHALL have port READ, input, 1 bit: the fetch request.
REQ-009 The block SHALL have port INSTRUCTION, output, 8*WORD_BYTES bits: the fetched word.
REQ-010 The block SHALL have port VALID, output, 1 bit: INSTRUCTION updated this cycle (one-cycle pulse).
REQ-011 The block SHALL have port BUSYWAIT, output, 1 bit: miss fetch in progress; the requester holds off.
REQ-012 The block SHALL have port MISALIGN, output, 1 bit: the last request was unaligned (one-cycle pulse).
REQ-013 The block SHALL have port LOAD_EN, input, 1 bit: the program-load byte write strobe.
REQ-014 The block SHALL have port LOAD_ADDR, input, ADDR_W bits: the program-load byte address.
REQ-015 The block SHALL have port LOAD_DATA, input, 8 bits: the program-load byte.

Function
REQ-016 The block SHALL use the byte address PC[ADDR_W-1:0] only, so addresses at or above 2^ADDR_W wrap modulo 2^ADDR_W.
REQ-017 The block SHALL assemble each word little-endian: byte at address a in bits [7:0], byte at a+WORD_BYTES-1 in the top byte.
REQ-018 The block SHALL keep a one-word fetch buffer holding a tag (word address), the data word and a valid bit.
REQ-019 The block SHALL implement states IDLE and FETCH; all outputs SHALL be registered.
REQ-020 When in IDLE and READ=1 with PC not a multiple of WORD_BYTES, the block SHALL set MISALIGN=1 for one cycle, hold INSTRUCTION, leave VALID=0 and stay in IDLE.
REQ-021 When in IDLE and READ=1 with an aligned PC matching a valid buffer tag (a hit), the block SHALL load INSTRUCTION from the buffer with VALID=1 on the next cycle, keep BUSYWAIT=0 and stay in IDLE.
REQ-022 When in IDLE and READ=1 with an aligned PC that misses the buffer, the block SHALL latch the address at that edge N, go to FETCH and hold BUSYWAIT=1 from edge N until edge N+READ_LAT.
REQ-023 At edge N+READ_LAT the block SHALL load INSTRUCTION with the assembled word, pulse VALID=1 for one cycle, set BUSYWAIT=0, refill the buffer (tag, data, valid=1) and return to IDLE.
REQ-024 While in FETCH the block SHALL ignore PC, READ and LOAD_EN (no memory write, no buffer change).
REQ-025 When in IDLE and LOAD_EN=1, the block SHALL write LOAD_DATA to LOAD_ADDR and clear the buffer valid bit; any READ in the same cycle SHALL be ignored (load has priority) and the requester must re-assert it.
REQ-026 While READ=0 in IDLE the block SHALL hold all outputs, with VALID=0 and MISALIGN=0.
REQ-027 Back-to-back hits SHALL give VALID=1 on consecutive cycles; a miss following a hit SHALL start in the cycle after the hit is sampled.

Reset
REQ-028 When RESET=1 at a clock edge, the block SHALL set state=IDLE, INSTRUCTION=0, VALID=0, BUSYWAIT=0, MISALIGN=0 and buffer valid=0, and SHALL not clear memory contents.
REQ-029 A reset during FETCH SHALL abandon the fetch with no VALID pulse; RESET SHALL take priority over READ and LOAD_EN.

Verification
REQ-030 Load bytes 0x05,0x00,0x04,0x00 at addresses 0..3, then READ with PC=0 -> BUSYWAIT=1 for 2 cycles, then VALID=1 with INSTRUCTION=0x00040005.
REQ-031 Repeat READ with PC=0 immediately after -> VALID=1 on the next cycle, BUSYWAIT stays 0, INSTRUCTION=0x00040005.
REQ-032 READ with PC=6 -> MISALIGN=1 for one cycle, VALID=0, INSTRUCTION unchanged, state stays IDLE.
REQ-033 READ with PC=0x400 (ADDR_W=10) -> treated as address 0 (wrap), miss latency 2, INSTRUCTION=0x00040005.
REQ-034 LOAD_EN at address 0 with data 0xFF, then READ with PC=0 -> buffer invalidated, miss path taken, INSTRUCTION=0x000400FF.
REQ-035 Assert RESET one cycle into a miss fetch -> no VALID pulse, BUSYWAIT=0 and INSTRUCTION=0 after the edge, memory intact (a subsequent fetch returns the loaded data).
